// File: rtl/digital_led_scan.sv
// digital_led_scan: multiplexed 7-segment scanner with per-slot blanking and tear-free frame snapshots
// Optional leading-zero blanking is enabled by defining DIGITAL_LED_SCAN_LZB_EN.
module digital_led_scan #(
    parameter int NDIG      = 3,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NDIG*4-1:0] bcd,
    input  logic [NDIG-1:0]   dp_in,
    output logic [NDIG-1:0]   sel,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              frame
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
    };
    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    state_t              state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [NDIG*4-1:0]   sh_bcd, sh_bcd_nxt;
    logic [NDIG-1:0]     sh_dp, sh_dp_nxt;
    logic [NDIG-1:0]     sel_nxt;
    logic [6:0]          seg_nxt;
    logic                dp_nxt, frame_nxt;
    logic [3:0]          nib;
    logic [NDIG-1:0]     dp_sh;
    logic                lz_blank;
    logic                show;
    assign nib   = 4'(sh_bcd >> {idx, 2'b00});
    assign dp_sh = sh_dp >> idx;
`ifdef DIGITAL_LED_SCAN_LZB_EN
    logic [NDIG*4-1:0] hi;
    assign hi       = sh_bcd >> {idx, 2'b00};
    assign lz_blank = (idx != '0) && (hi == '0);
`else
    assign lz_blank = 1'b0;
`endif
    // Next-state, slot timing, snapshot capture and registered-output precompute
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        idx_nxt    = idx;
        sh_bcd_nxt = sh_bcd;
        sh_dp_nxt  = sh_dp;
        frame_nxt  = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt  = BLANK;
                    cnt_nxt    = '0;
                    idx_nxt    = '0;
                    sh_bcd_nxt = bcd;
                    sh_dp_nxt  = dp_in;
                    frame_nxt  = 1'b1;
                end
                BLANK: begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = (cnt == CW'(BLANK_CYC - 1)) ? SHOW : BLANK;
                end
                SHOW: begin
                    if (cnt == CW'(DIV - 1)) begin
                        state_nxt = BLANK;
                        cnt_nxt   = '0;
                        if (idx == IW'(NDIG - 1)) begin
                            idx_nxt    = '0;
                            sh_bcd_nxt = bcd;
                            sh_dp_nxt  = dp_in;
                            frame_nxt  = 1'b1;
                        end else begin
                            idx_nxt = idx + 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        show    = (state_nxt == SHOW);
        sel_nxt = show ? (NDIG'(1) << idx) : '0;
        seg_nxt = (show && !lz_blank) ? SEG_LUT[nib] : 7'h00;
        dp_nxt  = show && dp_sh[0];
    end
    // State and output registers; outputs move on the same edge as the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            sh_bcd <= '0;
            sh_dp  <= '0;
            sel    <= '0;
            seg    <= '0;
            dp     <= 1'b0;
            frame  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            sh_bcd <= sh_bcd_nxt;
            sh_dp  <= sh_dp_nxt;
            sel    <= sel_nxt;
            seg    <= seg_nxt;
            dp     <= dp_nxt;
            frame  <= frame_nxt;
        end
    end
endmodule
